data_pipe: RTL

DATA_PIPE -- requirements
Module: data_pipe

---
 rtl/data_pipe_pkg.sv | 15 +
 rtl/data_pipe_stage.sv | 67 ++++++
 rtl/data_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/data_pipe_pkg.sv
// data_pipe_pkg
//   Shared defaults for the data_pipe register slice and its stage
//   sub-module, plus a small helper for sizing the occupancy count.
package data_pipe_pkg;

  localparam int DP_WIDTH       = 4;
  localparam int DP_DEPTH       = 3;
  localparam int DP_RESET_VALUE = 0;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_pipe_stage.sv
// pipe_stage
//   One slot of the data_pipe: a valid bit and a data register.  The slot
//   loads when upstream offers a beat and the slot is ready; it empties when
//   its beat moves on and nothing replaces it.  Flush clears the valid bit
//   and blocks any load, leaving the data register untouched.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous, active-high
//   flush_i        clear valid bit at next edge, block loads
//   up_valid_i     upstream slot (or pipe input) holds a beat
//   up_data_i      upstream payload
//   ready_i        this slot's ready, resolved by the parent's ready chain
//   down_ready_i   downstream slot (or pipe output) can take this slot's beat
//   valid_o        slot holds a beat
//   data_o         slot payload
module pipe_stage
  import data_pipe_pkg::*;
#(
  parameter int               WIDTH       = DP_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DP_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             ready_i,
  input  logic             down_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign load = up_valid_i && ready_i && !flush_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = up_data_i;
    end else if (down_ready_i) begin
      // Beat (if any) moved downstream and nothing replaced it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/data_pipe.sv
// data_pipe
//   DEPTH-stage valid/ready register pipeline with bubble collapsing.  A
//   stage is ready when it is empty or its own beat is leaving, so empty
//   slots keep filling even while the output is stalled, and a full pipe
//   still streams one beat per cycle when the output is ready.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high
//   flush       clear every stage valid bit at the next edge, accept nothing
//   in_valid    upstream beat present
//   in_ready    pipe accepts a beat this cycle
//   in_data     upstream payload
//   out_valid   last stage holds a beat (registered)
//   out_ready   downstream accepts a beat
//   out_data    last stage payload (registered)
//   occupancy   number of valid stages, 0..DEPTH
module data_pipe
  import data_pipe_pkg::*;
#(
  parameter int               WIDTH       = DP_WIDTH,
  parameter int               DEPTH       = DP_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DP_RESET_VALUE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH:0]   ready_w;
  logic [DEPTH-1:0] valid_w;
  logic [DEPTH-1:0] up_valid_w;
  logic [WIDTH-1:0] data_w    [DEPTH];
  logic [WIDTH-1:0] up_data_w [DEPTH];
  logic [OCC_W-1:0] occ_w;

  // Ready ripples back from the output; resolved in one block so the chain
  // is a plain combinational walk from out_ready toward the input.
  always_comb begin
    ready_w        = '0;
    ready_w[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready_w[i] = !valid_w[i] || ready_w[i+1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_first
        assign up_valid_w[g] = in_valid;
        assign up_data_w[g]  = in_data;
      end else begin : g_next
        assign up_valid_w[g] = valid_w[g-1];
        assign up_data_w[g]  = data_w[g-1];
      end

      pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush),
        .up_valid_i   (up_valid_w[g]),
        .up_data_i    (up_data_w[g]),
        .ready_i      (ready_w[g]),
        .down_ready_i (ready_w[g+1]),
        .valid_o      (valid_w[g]),
        .data_o       (data_w[g])
      );
    end
  endgenerate

  always_comb begin
    occ_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_w = occ_w + OCC_W'(valid_w[i]);
    end
  end

  assign in_ready  = ready_w[0] && !flush;
  assign out_valid = valid_w[DEPTH-1];
  assign out_data  = data_w[DEPTH-1];
  assign occupancy = occ_w;

endmodule
